// File: rtl/sin_frame_dispatcher.sv
// Frame engine between the SPI links and the UART bank: ROM-driven sine broadcast per phase,
// closed by a shoot pulse, plus a single-byte pipe mode to one addressed UART.
module sin_frame_dispatcher #(
  parameter int NUM_OF_MODULES = 9,
  parameter int NUM_OF_PHASES  = 3,
  parameter int ADDR_W         = 8,
  parameter int MODULE_OFFSET  = 28,
  parameter int PHASE_OFFSET   = 85,
  parameter int SIN_W          = 8,
  parameter int MA_W           = 16,
  parameter int SHOOT_CYCLES   = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            frame_valid,
  output logic                            frame_ready,
  input  logic [15:0]                     sin_index,
  input  logic [MA_W-1:0]                 ma_mult,
  input  logic                            pipe_valid,
  output logic                            pipe_ready,
  input  logic [7:0]                      pipe_id,
  input  logic [SIN_W-1:0]                pipe_data,
  output logic                            pipe_error,
  output logic [ADDR_W-1:0]               rom_addr,
  input  logic [SIN_W-1:0]                rom_data,
  output logic [NUM_OF_MODULES-1:0]       start_tx,
  output logic [NUM_OF_MODULES*SIN_W-1:0] data_to_tx,
  input  logic [NUM_OF_MODULES-1:0]       tx_busy,
  output logic                            shoot,
  output logic                            busy
);

  localparam int DW = NUM_OF_MODULES * SIN_W;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_TX   = 3'd2,
    SEND      = 3'd3,
    GUARD     = 3'd4,
    SHOOT     = 3'd5,
    PIPE_WAIT = 3'd6,
    PIPE_SEND = 3'd7
  } state_t;

  state_t                    state_r, next_s;
  logic [15:0]               idx_r;
  logic [MA_W-1:0]           ma_r;
  logic [4:0]                k_r;
  logic [2:0]                p_r;
  logic                      guard_r;
  logic [15:0]               shoot_cnt_r;
  logic                      pipe_mode_r;
  logic [NUM_OF_MODULES-1:0] id_mask_r, id_mask_s;
  logic [SIN_W-1:0]          pipe_data_r;
  logic [DW-1:0]             buf_r, data_r;
  logic [NUM_OF_MODULES-1:0] start_tx_r;
  logic [ADDR_W-1:0]         rom_addr_r;
  logic                      frame_ready_r, pipe_ready_r, pipe_error_r, shoot_r, busy_r;
  logic [SIN_W-1:0]          scaled_s;
  logic                      pipe_id_ok_s, last_phase_s;
  logic [4:0]                k_next_s;

  // Full 16-bit index is summed at 32 bits; truncation keeps only the table-address bits.
  function automatic logic [ADDR_W-1:0] addr_f(input logic [15:0] base, input logic [4:0] k,
                                               input logic [2:0] p);
    return ADDR_W'(32'(base) + 32'(k) * 32'(MODULE_OFFSET) + 32'(p) * 32'(PHASE_OFFSET));
  endfunction

  assign scaled_s     = SIN_W'(({{MA_W{1'b0}}, rom_data} * {{SIN_W{1'b0}}, ma_r}) >> MA_W);
  assign pipe_id_ok_s = (32'(pipe_id) < 32'(NUM_OF_MODULES));
  assign last_phase_s = (p_r == 3'(NUM_OF_PHASES - 1));
  assign k_next_s     = k_r + 5'd1;

  // One-hot mask of the requested pipe channel
  always_comb begin
    id_mask_s = {NUM_OF_MODULES{1'b0}};
    for (int m = 0; m < NUM_OF_MODULES; m++) begin
      id_mask_s[m] = (32'(pipe_id) == 32'(m));
    end
  end

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (frame_valid) next_s = LOAD;
        else if (pipe_valid && pipe_id_ok_s) next_s = PIPE_WAIT;
        else next_s = IDLE;
      end
      LOAD: begin
        if (32'(k_r) == 32'(NUM_OF_MODULES)) next_s = WAIT_TX;
        else next_s = LOAD;
      end
      WAIT_TX: begin
        if (|tx_busy) next_s = WAIT_TX;
        else next_s = SEND;
      end
      SEND: next_s = GUARD;
      GUARD: begin
        if (!guard_r) next_s = GUARD;
        else if (pipe_mode_r) next_s = IDLE;
        else if (last_phase_s) next_s = SHOOT;
        else next_s = LOAD;
      end
      SHOOT: begin
        if (shoot_cnt_r == 16'(SHOOT_CYCLES - 1)) next_s = IDLE;
        else next_s = SHOOT;
      end
      PIPE_WAIT: begin
        if (|(tx_busy & id_mask_r)) next_s = PIPE_WAIT;
        else next_s = PIPE_SEND;
      end
      PIPE_SEND: next_s = GUARD;
      default:   next_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= next_s;
  end

  // Datapath, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_r         <= 16'd0;
      ma_r          <= {MA_W{1'b0}};
      k_r           <= 5'd0;
      p_r           <= 3'd0;
      guard_r       <= 1'b0;
      shoot_cnt_r   <= 16'd0;
      pipe_mode_r   <= 1'b0;
      id_mask_r     <= {NUM_OF_MODULES{1'b0}};
      pipe_data_r   <= {SIN_W{1'b0}};
      buf_r         <= {DW{1'b0}};
      data_r        <= {DW{1'b0}};
      start_tx_r    <= {NUM_OF_MODULES{1'b0}};
      rom_addr_r    <= {ADDR_W{1'b0}};
      frame_ready_r <= 1'b1;
      pipe_ready_r  <= 1'b1;
      pipe_error_r  <= 1'b0;
      shoot_r       <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      start_tx_r    <= {NUM_OF_MODULES{1'b0}};
      pipe_error_r  <= 1'b0;
      frame_ready_r <= (next_s == IDLE);
      pipe_ready_r  <= (next_s == IDLE) && !frame_valid;
      busy_r        <= (next_s != IDLE);
      shoot_r       <= (next_s == SHOOT);
      case (state_r)
        IDLE: begin
          if (frame_valid) begin
            idx_r       <= sin_index;
            ma_r        <= ma_mult;
            p_r         <= 3'd0;
            k_r         <= 5'd0;
            pipe_mode_r <= 1'b0;
            rom_addr_r  <= addr_f(sin_index, 5'd0, 3'd0);
          end else if (pipe_valid && pipe_id_ok_s) begin
            id_mask_r   <= id_mask_s;
            pipe_data_r <= pipe_data;
            pipe_mode_r <= 1'b1;
          end else if (pipe_valid) begin
            pipe_error_r <= 1'b1;
          end
        end
        LOAD: begin
          // ROM answers one clock late, so cycle k stores the sample addressed in cycle k-1
          k_r <= k_next_s;
          if (32'(k_next_s) < 32'(NUM_OF_MODULES)) rom_addr_r <= addr_f(idx_r, k_next_s, p_r);
          for (int m = 0; m < NUM_OF_MODULES; m++) begin
            if (32'(k_r) == 32'(m + 1)) buf_r[m*SIN_W +: SIN_W] <= scaled_s;
          end
        end
        WAIT_TX: begin
          if (next_s == SEND) begin
            start_tx_r <= {NUM_OF_MODULES{1'b1}};
            data_r     <= buf_r;
          end
        end
        GUARD: begin
          guard_r <= ~guard_r;
          if (guard_r && !pipe_mode_r) begin
            if (last_phase_s) begin
              shoot_cnt_r <= 16'd0;
            end else begin
              p_r        <= p_r + 3'd1;
              k_r        <= 5'd0;
              rom_addr_r <= addr_f(idx_r, 5'd0, p_r + 3'd1);
            end
          end
        end
        SHOOT: shoot_cnt_r <= shoot_cnt_r + 16'd1;
        PIPE_SEND: begin
          start_tx_r <= id_mask_r;
          for (int m = 0; m < NUM_OF_MODULES; m++) begin
            if (id_mask_r[m]) data_r[m*SIN_W +: SIN_W] <= pipe_data_r;
          end
        end
        default: ;
      endcase
    end
  end

  assign frame_ready = frame_ready_r;
  assign pipe_ready  = pipe_ready_r;
  assign pipe_error  = pipe_error_r;
  assign rom_addr    = rom_addr_r;
  assign start_tx    = start_tx_r;
  assign data_to_tx  = data_r;
  assign shoot       = shoot_r;
  assign busy        = busy_r;

endmodule
